// File: rtl/pipe_delay.sv
// pipe_delay: programmable, stallable, valid-tagged delay line with a runtime output tap.
// Defining PIPE_DELAY_OCCUPANCY_EN adds an occupancy output counting samples in flight to the tap.
module pipe_delay #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 1,
  parameter int MAX_LENGTH = 16,
  localparam int DW = $clog2(MAX_LENGTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      flush,
  input  logic [DW-1:0]             delay_sel,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data
`ifdef PIPE_DELAY_OCCUPANCY_EN
  ,
  output logic [DW-1:0]             occupancy
`endif
);
  localparam int BW = CHANNELS * WIDTH;
  logic [MAX_LENGTH-1:0][BW-1:0] d_q, d_d;
  logic [MAX_LENGTH:0][BW-1:0] d_chain;
  logic [MAX_LENGTH:0] v_chain;
  logic [MAX_LENGTH-1:0] v_q, v_d;
  logic [DW-1:0] dq_q, dq_d;
  logic clr, tap_v;
  logic [BW-1:0] tap_d;
  always_comb begin
    dq_d = (delay_sel > DW'(MAX_LENGTH)) ? DW'(MAX_LENGTH) : delay_sel;
    clr = reset | flush | (dq_d != dq_q);
    d_chain = {d_q, in_data};
    v_chain = {v_q, in_valid};
    d_d = reset ? '0 : (en && !flush) ? d_chain[MAX_LENGTH-1:0] : d_q;
    v_d = clr ? '0 : en ? v_chain[MAX_LENGTH-1:0] : v_q;
    tap_v = 1'b0;
    tap_d = '0;
    for (int i = 0; i < MAX_LENGTH; i++)
      if (dq_q == DW'(i + 1)) begin
        tap_v = v_q[i] & ~reset;
        tap_d = d_q[i];
      end
    // A zero delay bypasses the registers entirely, so it ignores en, flush and reset.
    out_valid = (dq_q == '0) ? in_valid : tap_v;
    out_data = !out_valid ? '0 : (dq_q == '0) ? in_data : tap_d;
  end
`ifdef PIPE_DELAY_OCCUPANCY_EN
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < MAX_LENGTH; i++)
      occupancy += (DW'(i) < dq_q && !reset) ? DW'(v_q[i]) : '0;
  end
`endif
  always_ff @(posedge clk) begin
    d_q <= d_d;
    v_q <= v_d;
    dq_q <= dq_d;
  end
endmodule

// File: doc/pipe_delay.md
Name: pipe_delay

Overview:
Programmable, stallable, valid-tagged delay line for aligning multi-channel pixel and control pipelines. It is built as a shift register of MAX_LENGTH stages with a runtime-selected output tap. Each stage carries a valid bit, and the register advances only when the enable input is high. It sits between stages of the render/scanout pipeline whose latencies differ by mode.

Parameters:
WIDTH, 8, bits per channel
CHANNELS, 1, number of parallel channels; data buses are CHANNELS*WIDTH bits, channel c at bits [c*WIDTH +: WIDTH]
MAX_LENGTH, 16, number of physical stages (>=1); maximum selectable delay
DW, $clog2(MAX_LENGTH+1), width of the delay select (localparam)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
en  input  1  advance pipeline this cycle
flush  input  1  invalidate all in-flight samples
delay_sel  input  DW  requested delay in enabled cycles (0..MAX_LENGTH)
in_valid  input  1  input sample valid
in_data  input  CHANNELS*WIDTH  input sample
out_valid  output  1  output sample valid
out_data  output  CHANNELS*WIDTH  output sample; all zeros when out_valid=0

Behaviour:
- Clock and reset: clk is the clock. reset is synchronous, active-high.
- State:
  - stage data d[0..MAX_LENGTH-1] and valid bits v[0..MAX_LENGTH-1];
  - registered delay dq (DW bits).
- Clamping: delay_sel > MAX_LENGTH is treated as MAX_LENGTH. Call the clamped value ds.
- Reset:
  - all d and v cleared to 0;
  - dq <= ds;
  - during reset out_valid=0 and out_data=0, with the exception of dq=0 passthrough (see tap selection).
- Shift, on posedge clk when not reset, en=1 and flush=0:
  - d[0] <= in_data, v[0] <= in_valid;
  - d[i] <= d[i-1], v[i] <= v[i-1] for i=1..MAX_LENGTH-1.
  - Data registers shift regardless of valid; invalid samples occupy slots, forming bubbles.
- Stall, en=0: all d and v hold. The output holds the selected stage.
- Flush, flush=1:
  - all v <= 0 on that edge, including the sample presented at the input that cycle;
  - d holds;
  - flush has priority over en.
- Tap selection (combinational from dq):
  - dq=k>=1: out_valid = v[k-1], out_data = v[k-1] ? d[k-1] : 0. Latency is exactly k enabled clock edges.
  - dq=0: passthrough. out_valid = in_valid, out_data = in_valid ? in_data : 0. Passthrough is unaffected by en, flush and reset.
- Delay change:
  - every cycle, if ds != dq, then dq <= ds and all v <= 0 on the same edge (implicit flush).
  - The cycle in which delay_sel changes still uses the old dq.
  - From the next cycle the new tap is used, with an empty pipe.
  - A change coinciding with en=1 still shifts d, but v is cleared.
- Simultaneous events, priority: reset > (flush or delay change) > shift > hold.
- No backpressure: the block never drops or reorders valid samples except via flush, delay change or reset.

Optional Feature:
Macro PIPE_DELAY_OCCUPANCY_EN.
- Defined:
  - adds output port occupancy, DW bits;
  - occupancy = number of set v[i] for i < dq, i.e. valid samples in flight toward the active tap, computed combinationally;
  - occupancy is 0 when dq=0 and 0 after reset or flush.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Fixed latency: CHANNELS=2, WIDTH=8, delay_sel=5, en=1, in_valid=1, in_data=0x0100+n on cycle n -> out_data=0x0100+(n-5), out_valid=1 from cycle 5 onward; out_valid=0, out_data=0 for cycles 0-4.
- Stall: delay_sel=3, feed A,B,C,D with en=1; then en=0 for 4 cycles; then en=1 -> output freezes on the current sample during the stall; the sequence resumes without loss or duplication; total latency = 3 enabled edges.
- Bubbles and flush: delay_sel=4, in_valid pattern 1,0,1,1; flush pulsed one cycle while samples are in flight -> out_valid stays 0 until 4 enabled edges after the next valid input; the sample input on the flush cycle is never output.
- Delay change: delay_sel switches 4->2 mid-stream -> old tap is used on the switch cycle; from the next cycle out_valid=0 until new data has traversed 2 stages; no stale samples appear.
- Boundaries:
  - delay_sel=0 -> out equals in within the same cycle, including while reset=1;
  - delay_sel=MAX_LENGTH+3 -> latency = MAX_LENGTH;
  - MAX_LENGTH=1 builds and works.
- Reset mid-stream, with PIPE_DELAY_OCCUPANCY_EN defined: delay_sel=8, 6 valid samples in flight -> occupancy=6; assert reset for one cycle -> out_valid=0, occupancy=0; subsequent samples appear after 8 edges.
